// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter: round-robin owner of the shared FFT datapath, one frame per grant,
// held until the FFT output frame drains, with length enforcement and a progress watchdog.
module fft_frame_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int DATA_WIDTH     = 64,
   parameter int FRAME_LEN      = 8192,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_REQ-1:0]            s_tvalid,
   input  logic [NUM_REQ-1:0]            s_tlast,
   output logic [NUM_REQ-1:0]            s_tready,
   input  logic                          fft_idle,
   output logic                          fft_start,
   output logic [DATA_WIDTH-1:0]         m_tdata,
   output logic                          m_tvalid,
   output logic                          m_tlast,
   input  logic                          m_tready,
   input  logic                          o_tvalid,
   input  logic                          o_tready,
   input  logic                          o_tlast,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy,
   output logic [CNT_WIDTH-1:0]          frame_count,
   output logic                          overlength,
   output logic                          timeout_err,
   input  logic                          clear_err
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int BW  = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
   localparam int WW  = $clog2(TIMEOUT_CYCLES);
   typedef enum logic [2:0] {IDLE, START, STREAM, FLUSH, DRAIN} state_t;
   state_t               state_q, state_d;
   logic [IDW-1:0]       grant_q, grant_d, rr_q, rr_d, pick, next_rr;
   logic [BW-1:0]        beat_q, beat_d;
   logic [WW-1:0]        wd_q, wd_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 ovl_q, ovl_d, tmo_q, tmo_d;
   logic                 sel_valid, sel_last, at_end, m_hs, f_hs, o_hs, progress, ovl_set, tmo;
   logic                 found;
   logic [DATA_WIDTH-1:0] sel_data;
   int                   idx;
   // First pending requester at or after rr_q, wrapping around.
   always_comb begin
      pick  = rr_q;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_q) + i) % NUM_REQ;
         if (!found && req[idx]) begin
            pick  = IDW'(idx);
            found = 1'b1;
         end
      end
   end
   assign next_rr   = IDW'((int'(grant_q) + 1) % NUM_REQ);
   assign sel_data  = s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_valid = s_tvalid[grant_q];
   assign sel_last  = s_tlast[grant_q];
   assign at_end    = beat_q == BW'(FRAME_LEN - 1);
   assign m_hs      = state_q == STREAM && sel_valid && m_tready;
   assign f_hs      = state_q == FLUSH && sel_valid;
   assign o_hs      = o_tvalid && o_tready;
   assign progress  = m_hs || f_hs || o_hs;
   assign tmo       = state_q != IDLE && !progress && wd_q == WW'(TIMEOUT_CYCLES - 1);
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      ovl_set = 1'b0;
      case (state_q)
         IDLE:    if (|req && fft_idle) begin
                     state_d = START;
                     grant_d = pick;
                  end
         START:   begin
                     state_d = STREAM;
                     beat_d  = '0;
                  end
         STREAM:  if (m_hs) begin
                     beat_d = beat_q + BW'(1);
                     if (sel_last) state_d = DRAIN;
                     else if (at_end) begin
                        ovl_set = 1'b1;
                        state_d = FLUSH;
                     end
                  end
         FLUSH:   if (f_hs && sel_last) state_d = DRAIN;
         DRAIN:   if (o_hs && o_tlast) begin
                     state_d = IDLE;
                     cnt_d   = cnt_q + CNT_WIDTH'(1);
                     rr_d    = next_rr;
                  end
         default: state_d = IDLE;
      endcase
      if (tmo) begin
         state_d = IDLE;
         rr_d    = next_rr;
      end
      wd_d  = (state_q == IDLE || state_d != state_q || progress) ? '0 : wd_q + WW'(1);
      ovl_d = ovl_set || (ovl_q && !clear_err);
      tmo_d = tmo || (tmo_q && !clear_err);
   end
   always_comb begin
      s_tready          = '0;
      s_tready[grant_q] = state_q == STREAM ? m_tready : state_q == FLUSH;
   end
   assign m_tdata     = state_q == STREAM ? sel_data : '0;
   assign m_tvalid    = state_q == STREAM && sel_valid;
   assign m_tlast     = state_q == STREAM && (sel_last || at_end);
   assign fft_start   = state_q == START;
   assign busy        = state_q != IDLE;
   assign grant_id    = grant_q;
   assign frame_count = cnt_q;
   assign overlength  = ovl_q;
   assign timeout_err = tmo_q;
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         beat_q  <= '0;
         wd_q    <= '0;
         cnt_q   <= '0;
         ovl_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         beat_q  <= beat_d;
         wd_q    <= wd_d;
         cnt_q   <= cnt_d;
         ovl_q   <= ovl_d;
         tmo_q   <= tmo_d;
      end
   end
endmodule
